// File: rtl/pack_dp_pkg.sv
// Shared types and default sizing for the beat-packing data path.
package pack_dp_pkg;

  localparam int W_DEF     = 4;
  localparam int BEATS_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/pack_data_path_if.sv
// Producer/consumer bundle for pack_data_path: beat input, word output and status.
interface pack_data_path_if
  import pack_dp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int BEATS = BEATS_DEF
);
  localparam int CW = $clog2(BEATS + 1);

  // A beat transfers on a rising edge where en && rdy; the packed word is
  // offered while done is high and is released on the edge where ack is high.
  logic                   en;
  logic [W-1:0]           A;
  logic [W-1:0]           B;
  logic                   msb_first;
  logic                   rdy;
  logic                   ack;
  logic [2*W*BEATS-1:0]   data_path_out;
  logic                   done;
  logic [CW-1:0]          beat_cnt;
  logic                   ovf;
  state_t                 state;

  modport master (
    output en, A, B, msb_first, ack,
    input  rdy, data_path_out, done, beat_cnt, ovf, state
  );

  modport slave (
    input  en, A, B, msb_first, ack,
    output rdy, data_path_out, done, beat_cnt, ovf, state
  );

endinterface

// File: rtl/pack_slot_write.sv
// Combinational slot writer: places one {A,B} beat into its slot of the word.
module pack_slot_write
  import pack_dp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int BEATS = BEATS_DEF,
  parameter int CW    = $clog2(BEATS + 1)
) (
  input  logic [2*W*BEATS-1:0] word,
  input  logic [CW-1:0]        idx,
  input  logic                 order,
  input  logic [2*W-1:0]       ab,
  output logic [2*W*BEATS-1:0] upd
);

  int tgt;

  // order=1 fills from the top slot downward, order=0 from the bottom up.
  always_comb begin
    tgt = order ? (BEATS - 1 - int'(idx)) : int'(idx);
    upd = word;
    for (int s = 0; s < BEATS; s++) begin
      if (s == tgt) upd[s*2*W +: 2*W] = ab;
    end
  end

endmodule

// File: rtl/pack_data_path.sv
// Packs BEATS consecutive {A,B} beats into one word and holds it until ack.
module pack_data_path
  import pack_dp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int BEATS = BEATS_DEF
) (
  input  logic           clk,
  input  logic           clr,
  pack_data_path_if.slave bus
);

  localparam int WW = 2 * W * BEATS;
  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  state_t          state_q;
  state_t          state_d;
  logic [WW-1:0]   word_q;
  logic [WW-1:0]   base_word;
  logic [WW-1:0]   slot_word;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   slot_idx;
  logic [CW-1:0]   cnt_inc;
  logic            order_q;
  logic            slot_order;
  logic            done_q;
  logic            ovf_q;
  logic            rdy;
  logic            accept;
  logic            first;

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FILL: begin
        if (accept) state_d = (cnt_inc == BEATS_C) ? HOLD : FILL;
      end
      HOLD: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat 0 starts from an all-zero word and takes the live order input;
  // later beats extend the held word using the order latched at beat 0.
  always_comb begin
    rdy        = (state_q != HOLD);
    accept     = bus.en && rdy;
    first      = (state_q == IDLE);
    base_word  = first ? '0 : word_q;
    slot_idx   = first ? '0 : cnt_q;
    slot_order = first ? bus.msb_first : order_q;
    cnt_inc    = slot_idx + CW'(1);
  end

  pack_slot_write #(
    .W     (W),
    .BEATS (BEATS),
    .CW    (CW)
  ) u_slot_write (
    .word  (base_word),
    .idx   (slot_idx),
    .order (slot_order),
    .ab    ({bus.A, bus.B}),
    .upd   (slot_word)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      word_q  <= '0;
      cnt_q   <= '0;
      order_q <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= (state_d == HOLD);
      if (accept) begin
        word_q <= slot_word;
        cnt_q  <= cnt_inc;
        if (first) order_q <= bus.msb_first;
      end
      if (state_q == HOLD && bus.ack) cnt_q <= '0;
      // A beat offered while full is lost; remember that until clr.
      if (state_q == HOLD && bus.en) ovf_q <= 1'b1;
    end
  end

  assign bus.rdy           = rdy;
  assign bus.data_path_out = word_q;
  assign bus.done          = done_q;
  assign bus.beat_cnt      = cnt_q;
  assign bus.ovf           = ovf_q;
  assign bus.state         = state_q;

endmodule

// File: doc/pack_data_path.md
PACK_DATA_PATH -- requirements
Module: pack_data_path

Interface
REQ-001 Parameter W, default 4: operand width in bits (W >= 1).
REQ-002 Parameter BEATS, default 2: beats packed per output word (BEATS >= 1).
REQ-003 The clock, clk, shall be input, 1 bit; it is the single clock, and all state updates occur on its rising edge.
REQ-004 The reset, clr, shall be input, 1 bit; it is synchronous and active-high.
REQ-005 en: input, 1 bit; beat valid.
REQ-006 A: input, W bits; upper operand of the beat.
REQ-007 B: input, W bits; lower operand of the beat.
REQ-008 msb_first: input, 1 bit; word packing order, sampled on beat 0 only.
REQ-009 rdy: output, 1 bit; block accepts a beat this cycle.
REQ-010 ack: input, 1 bit; consumer takes the completed word.
REQ-011 data_path_out: output reg, 2*W*BEATS bits; packed word.
REQ-012 done: output reg, 1 bit; data_path_out holds a complete word.
REQ-013 beat_cnt: output, $clog2(BEATS+1) bits; beats stored in the current word.
REQ-014 ovf: output reg, 1 bit; sticky flag for a beat offered while full.

Function
REQ-015 The FSM shall have exactly three states: IDLE, FILL and HOLD.
REQ-016 A beat shall be accepted only when en=1 and rdy=1; rdy shall be 1 in IDLE and FILL and 0 in HOLD.
REQ-017 Each beat slot shall contain {A,B}, with A in the upper W bits.
REQ-018 When msb_first=1, beat k shall be written to bits [(BEATS-k)*2W-1 : (BEATS-k-1)*2W].
REQ-019 When msb_first=0, beat k shall be written to bits [(k+1)*2W-1 : k*2W].
REQ-020 IDLE + accept: zero all slots except beat 0, write beat 0, latch msb_first, and set beat_cnt=1.
REQ-021 From IDLE + accept: go to HOLD if BEATS=1, otherwise go to FILL.
REQ-022 In FILL + accept: write the slot at index beat_cnt and increment beat_cnt; go to HOLD when the post-increment count equals BEATS.
REQ-023 IDLE/FILL with en=0: all state, beat_cnt and data_path_out shall be held; gaps between beats are allowed.
REQ-024 done shall be 1 exactly while in HOLD, first asserting the cycle after the edge that accepted the last beat.
REQ-025 In HOLD: data_path_out and beat_cnt (=BEATS) shall be stable until ack=1.
REQ-026 HOLD + ack=1: go to IDLE and set beat_cnt=0; done=0 and rdy=1 from the next cycle, and data_path_out is retained until the next beat 0.
REQ-027 ack shall be ignored outside HOLD.
REQ-028 en=1 in HOLD (including the ack cycle): the beat shall be dropped and ovf shall be set; ovf stays set until clr.
REQ-029 A change to msb_first in the middle of a word shall have no effect on the current word.

Reset
REQ-030 clr=1 at a clock edge: state=IDLE, data_path_out=0, done=0, beat_cnt=0, ovf=0, latched order=1 (msb_first).
REQ-031 clr shall take priority over en and ack in the same cycle, including mid-FILL and in HOLD; a partial word is discarded.
REQ-032 Output values before the first clr are undefined; the bench shall apply clr for at least 1 cycle at startup.

Structure
REQ-033 A shared package pack_dp_pkg shall hold the state enum (IDLE/FILL/HOLD) and the default W and BEATS localparams.
REQ-034 There shall be one sub-module, pack_slot_write (combinational): inputs are the current word, slot index, order and {A,B}; output is the updated word.
REQ-035 All outputs except rdy and beat_cnt shall be registered; rdy shall be decoded from state only, with no combinational path from en or ack.

Verification
REQ-036 W=4, BEATS=2, msb_first=1, beats (3,5) then (A,C) -> data_path_out=16'h35AC, done=1 one cycle after the 2nd beat, held until ack.
REQ-037 Same beats with msb_first=0 -> data_path_out=16'hAC35, beat_cnt=2 in HOLD.
REQ-038 Beat (3,5), 4 idle cycles, then beat (A,C) -> beat_cnt=1 throughout the gap, final word 16'h35AC, done never asserted early.
REQ-039 In HOLD, en=1 with (F,F) for 2 cycles and no ack -> ovf=1, word unchanged at 16'h35AC; ack=1 -> next cycle done=0, rdy=1, ovf still 1.
REQ-040 After beat (3,5), clr=1 with en=1 in the same cycle -> data_path_out=0, beat_cnt=0, IDLE; the next word (1,2),(3,4) with msb_first=1 -> 16'h1234.
REQ-041 W=8, BEATS=1, A=8'h12, B=8'h34, en=1 for one cycle -> data_path_out=16'h1234, done=1 the next cycle and held until ack.
